spi_master_param: RTL and testbench
===================================

Name: spi_master_param

Overview:
- Parametrised successor to the team's fixed 12-bit, transmit-only SPI master.
- Generalisations: configurable word width and SCLK divider, all four SPI modes (CPOL/CPHA), MSB- or LSB-first order, full-duplex MISO capture, busy/done handshake.
- Sits between on-chip control logic and one external SPI slave; one transfer per newd strobe.

Parameters:
- DATA_W, 12, bits per transfer; must be ≥ 2.
- CLK_DIV, 4, clk cycles per SCLK half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- newd  in  1  start strobe; accepted only when busy=0.
- din  in  DATA_W  transmit word, sampled with newd.
- cpol  in  1  clock polarity, sampled with newd.
- cpha  in  1  clock phase, sampled with newd.
- lsb_first  in  1  bit order (0 = MSB first), sampled with newd.
- miso  in  1  serial data from the slave.
- cs  out  1  active-low chip select.
- sclk  out  1  serial clock.
- mosi  out  1  serial data to the slave.
- dout  out  DATA_W  received word; valid from done until the next accept.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle pulse at the end of a transfer.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs go immediately to cs=1, sclk=0, mosi=0, dout=0, busy=0, done=0.
  - Latched mode registers clear to 0; state goes to IDLE.
  - Reset during a transfer aborts it with no done pulse.
- Registered outputs: all outputs are registered; no combinational path from any input to any output.
- IDLE:
  - cs=1, busy=0, mosi=0.
  - sclk follows the cpol input with one cycle of delay.
- Accept: newd=1 with busy=0 at edge T.
  - Latch din, cpol, cpha, lsb_first.
  - From T+1: cs=0, busy=1, state SETUP.
  - newd while busy=1 is ignored; no queueing, no side effects.
- SETUP: lasts CLK_DIV cycles, sclk=CPOL.
  - cpha=0: mosi presents the first bit from T+1.
  - cpha=1: mosi stays at 0 until the first leading edge.
- XFER:
  - sclk toggles every CLK_DIV cycles; the first toggle (leading edge) occurs at T+1+CLK_DIV.
  - There are 2*DATA_W edges; the last trailing edge is at T+1+2*DATA_W*CLK_DIV.
  - cpha=0: miso is sampled at the leading-edge clk cycle; the next bit shifts onto mosi at the trailing edge.
  - cpha=1: the bit shifts onto mosi at the leading edge; miso is sampled at the trailing edge.
  - "Sampled" means miso is captured at the same clk posedge that updates the sclk register.
- HOLD: lasts CLK_DIV cycles, with sclk=CPOL and cs=0. mosi holds the last bit.
- Completion, at edge T+1+(2*DATA_W+1)*CLK_DIV:
  - cs=1, busy=0, done=1 for one cycle, dout updated, return to IDLE.
  - Defaults (DATA_W=12, CLK_DIV=4): completion at T+101.
- Back-to-back:
  - newd in the done cycle is accepted, because busy is already 0.
  - cs is therefore high for exactly one cycle between transfers.
- Bit order:
  - MSB first: din[DATA_W-1] is sent first, and the first received bit lands in dout[DATA_W-1].
  - LSB first: din[0] is sent first, and the first received bit lands in dout[0].
  - With a loopback (miso tied to mosi), dout equals din in both orders.
- Counters:
  - Divider counter width $clog2(CLK_DIV+1).
  - Edge counter width $clog2(2*DATA_W+1).
  - Both counters reload at every state entry; no wrap-around is visible externally.

Decomposition:
- Shared package spi_pkg holds:
  - enum spi_state_e {IDLE, SETUP, XFER, HOLD};
  - packed struct spi_mode_t {cpol, cpha, lsb_first}.
- One sub-module, spi_sclk_tick:
  - Parametrised by CLK_DIV.
  - Produces a one-cycle tick every CLK_DIV clk cycles while enabled.
  - Counter clears when disabled.
- The FSM, shift registers and output registers live in the top module.

Test Plan:
1. Mode 0, MSB first, loopback (miso=mosi), din=12'hD59, newd pulsed at T:
   - cs falls at T+1; mosi bit sequence 1,1,0,1,0,1,0,1,1,0,0,1.
   - done at T+101; dout=12'hD59; sclk idles at 0.
2. Mode 3, slave model drives 12'h5A3 on miso (changing on leading edges), din=12'hAAA:
   - sclk idles at 1; dout=12'h5A3.
   - mosi matches 12'hAAA sampled on the trailing (rising) edges.
3. Mode 1, lsb_first=1, din=12'h001:
   - mosi is 1 at the first leading edge, then 0 for the remaining 11 bits.
   - Loopback gives dout=12'h001.
4. Second newd at T+40 during a transfer, din=12'hFFF:
   - Ignored; the first transfer completes with its own data.
   - newd asserted in the done cycle with din=12'h0F0 is accepted; cs is high for exactly one cycle.
5. rst_n driven low at T+50 mid-transfer:
   - cs=1, sclk=0, busy=0 immediately; no done pulse.
   - After release, a new transfer with din=12'h3C3 completes correctly.
6. Override CLK_DIV=1, DATA_W=8, mode 2, loopback, din=8'hA5:
   - sclk half-period is one cycle; done at T+18; dout=8'hA5.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM states and the per-transfer mode.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

endpackage

// File: rtl/spi_sclk_tick.sv
// Divider that emits a one-cycle tick every CLK_DIV clk cycles while enabled.
module spi_sclk_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (!en || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Full-duplex SPI master with configurable width, divider, CPOL/CPHA and bit order.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              newd,
    input  logic [DATA_W-1:0] din,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              miso,
    output logic              cs,
    output logic              sclk,
    output logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EW = $clog2(2 * DATA_W + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    spi_mode_t         mode_q, mode_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              tick, lead, trail, last, sample, shift;

    spi_sclk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // edge_q counts sclk edges already produced; even count means the next one is leading.
    always_comb begin
        lead   = tick && (state_q == SETUP || state_q == XFER) && !edge_q[0];
        trail  = tick && (state_q == XFER) && edge_q[0];
        last   = (state_q == XFER) && (edge_q == LAST_EDGE);
        sample = mode_q.cpha ? trail : lead;
        shift  = mode_q.cpha ? lead : (trail && !last);
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        edge_d  = edge_q;
        cs_d    = cs_q;
        sclk_d  = sclk_q;
        mosi_d  = mosi_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                cs_d   = 1'b1;
                busy_d = 1'b0;
                mosi_d = 1'b0;
                sclk_d = cpol;
                if (newd) begin
                    mode_d.cpol      = cpol;
                    mode_d.cpha      = cpha;
                    mode_d.lsb_first = lsb_first;
                    state_d          = SETUP;
                    cs_d             = 1'b0;
                    busy_d           = 1'b1;
                    rx_d             = '0;
                    edge_d           = '0;
                    tx_d             = din;
                    // CPHA=0 must have the first bit valid before the first leading edge.
                    if (!cpha) begin
                        mosi_d = lsb_first ? din[0] : din[DATA_W-1];
                        tx_d   = lsb_first ? (din >> 1) : (din << 1);
                    end
                end
            end
            SETUP, XFER: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + EW'(1);
                    if (state_q == SETUP) begin
                        state_d = XFER;
                    end else if (last) begin
                        state_d = HOLD;
                        edge_d  = '0;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    cs_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    mosi_d  = 1'b0;
                    sclk_d  = cpol;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            rx_d = mode_q.lsb_first ? {miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso};
        end
        if (shift) begin
            mosi_d = mode_q.lsb_first ? tx_q[0] : tx_q[DATA_W-1];
            tx_d   = mode_q.lsb_first ? (tx_q >> 1) : (tx_q << 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            edge_q  <= '0;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            edge_q  <= edge_d;
            cs_q    <= cs_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cs   = cs_q;
    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign dout = dout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: default 12-bit/div-4 instance plus an 8-bit/div-1 one.
module tb_spi_master_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        newd = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic [11:0] din = '0;
    logic        loop = 1'b1, miso_drv = 1'b0;
    logic        miso, cs, sclk, mosi, busy, done;
    logic [11:0] dout;

    logic       newd8 = 1'b0, cpol8 = 1'b0, cpha8 = 1'b0, lsb8 = 1'b0;
    logic [7:0] din8 = '0;
    logic       miso8, cs8, sclk8, mosi8, busy8, done8;
    logic [7:0] dout8;

    int errs = 0;
    int checks = 0;

    // Results of the most recent watch() call.
    int          w_done_k, w_nlead, w_ntrail;
    logic [11:0] w_dout, w_lead, w_trail;
    logic        w_cs_bad, w_cs_done, w_cs_k1, w_busy_k1, w_idle_sclk;

    always #5 clk = ~clk;

    assign miso  = loop ? mosi : miso_drv;
    assign miso8 = mosi8;

    spi_master_param dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .newd     (newd),
        .din      (din),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb_first(lsb_first),
        .miso     (miso),
        .cs       (cs),
        .sclk     (sclk),
        .mosi     (mosi),
        .dout     (dout),
        .busy     (busy),
        .done     (done)
    );

    spi_master_param #(
        .DATA_W (8),
        .CLK_DIV(1)
    ) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .newd     (newd8),
        .din      (din8),
        .cpol     (cpol8),
        .cpha     (cpha8),
        .lsb_first(lsb8),
        .miso     (miso8),
        .cs       (cs8),
        .sclk     (sclk8),
        .mosi     (mosi8),
        .dout     (dout8),
        .busy     (busy8),
        .done     (done8)
    );

    // Set the mode, let sclk settle in idle, then raise newd for the next edge.
    task automatic launch(input logic [11:0] d, input logic pol, input logic pha,
                          input logic lsb, input logic lp);
        loop      = lp;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        @(posedge clk);
        @(posedge clk);
        #1;
        w_idle_sclk = sclk;
        newd = 1'b1;
        din  = d;
    endtask

    // Step from the accepting edge (k=1 is the first sample after it) until done or max_k.
    // Acts as a CPHA=1 slave driving sw MSB first on leading edges when loop is off.
    task automatic watch(input int max_k, input int inject_k, input logic [11:0] sw);
        logic prev;
        int   sidx;
        w_done_k = 0; w_nlead = 0; w_ntrail = 0; w_lead = '0; w_trail = '0;
        w_cs_bad = 1'b0; w_cs_done = 1'b0; sidx = 0;
        prev = sclk;
        for (int k = 1; k <= max_k && w_done_k == 0; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                newd = 1'b0;
                w_cs_k1 = cs;
                w_busy_k1 = busy;
            end
            if (k == inject_k) begin
                newd = 1'b1;
                din  = 12'hFFF;
            end
            if (k == inject_k + 1) newd = 1'b0;
            if (sclk !== prev) begin
                if (prev === cpol) begin
                    w_lead = {w_lead[10:0], mosi};
                    w_nlead++;
                    if (!loop && sidx < 12) begin
                        miso_drv = sw[11-sidx];
                        sidx++;
                    end
                end else begin
                    w_trail = {w_trail[10:0], mosi};
                    w_ntrail++;
                end
                prev = sclk;
            end
            if (done === 1'b1) begin
                w_done_k  = k;
                w_dout    = dout;
                w_cs_done = cs;
            end else if (cs !== 1'b0) begin
                w_cs_bad = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (cs !== 1'b1) begin errs++; $display("FAIL rst_cs: got %b want 1", cs); end
        checks++; if (sclk !== 1'b0) begin errs++; $display("FAIL rst_sclk: got %b want 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errs++; $display("FAIL rst_mosi: got %b want 0", mosi); end
        checks++; if (dout !== 12'h000) begin errs++; $display("FAIL rst_dout: got %h want 000", dout); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL rst_done: got %b want 0", done); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mode0_msb;
        launch(12'hD59, 1'b0, 1'b0, 1'b0, 1'b1);
        watch(300, 0, 12'h000);
        checks++; if (w_idle_sclk !== 1'b0) begin errs++; $display("FAIL m0_idle_sclk: got %b want 0", w_idle_sclk); end
        checks++; if (w_cs_k1 !== 1'b0) begin errs++; $display("FAIL m0_cs_fall: got %b want 0", w_cs_k1); end
        checks++; if (w_busy_k1 !== 1'b1) begin errs++; $display("FAIL m0_busy: got %b want 1", w_busy_k1); end
        checks++; if (w_cs_bad !== 1'b0) begin errs++; $display("FAIL m0_cs_low: cs rose early, want low until done"); end
        checks++; if (w_nlead != 12) begin errs++; $display("FAIL m0_nlead: got %0d want 12", w_nlead); end
        checks++; if (w_lead !== 12'hD59) begin errs++; $display("FAIL m0_mosi_seq: got %h want d59", w_lead); end
        checks++; if (w_done_k != 101) begin errs++; $display("FAIL m0_done_k: got %0d want 101", w_done_k); end
        checks++; if (w_dout !== 12'hD59) begin errs++; $display("FAIL m0_dout: got %h want d59", w_dout); end
        checks++; if (w_cs_done !== 1'b1) begin errs++; $display("FAIL m0_cs_done: got %b want 1", w_cs_done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL m0_done_pulse: got %b want 0", done); end
        checks++; if (sclk !== 1'b0) begin errs++; $display("FAIL m0_sclk_after: got %b want 0", sclk); end
    endtask

    task automatic test_mode3_slave;
        miso_drv = 1'b0;
        launch(12'hAAA, 1'b1, 1'b1, 1'b0, 1'b0);
        watch(300, 0, 12'h5A3);
        checks++; if (w_idle_sclk !== 1'b1) begin errs++; $display("FAIL m3_idle_sclk: got %b want 1", w_idle_sclk); end
        checks++; if (w_ntrail != 12) begin errs++; $display("FAIL m3_ntrail: got %0d want 12", w_ntrail); end
        checks++; if (w_trail !== 12'hAAA) begin errs++; $display("FAIL m3_mosi_seq: got %h want aaa", w_trail); end
        checks++; if (w_done_k != 101) begin errs++; $display("FAIL m3_done_k: got %0d want 101", w_done_k); end
        checks++; if (w_dout !== 12'h5A3) begin errs++; $display("FAIL m3_dout: got %h want 5a3", w_dout); end
        @(posedge clk); #1;
        checks++; if (sclk !== 1'b1) begin errs++; $display("FAIL m3_sclk_after: got %b want 1", sclk); end
    endtask

    task automatic test_mode1_lsb;
        launch(12'h001, 1'b0, 1'b1, 1'b1, 1'b1);
        watch(300, 0, 12'h000);
        checks++; if (w_lead !== 12'h800) begin errs++; $display("FAIL m1_mosi_seq: got %h want 800", w_lead); end
        checks++; if (w_done_k != 101) begin errs++; $display("FAIL m1_done_k: got %0d want 101", w_done_k); end
        checks++; if (w_dout !== 12'h001) begin errs++; $display("FAIL m1_dout: got %h want 001", w_dout); end
    endtask

    task automatic test_back_to_back;
        launch(12'h3A5, 1'b0, 1'b0, 1'b0, 1'b1);
        watch(300, 40, 12'h000);
        checks++; if (w_done_k != 101) begin errs++; $display("FAIL b2b_done_k: got %0d want 101", w_done_k); end
        checks++; if (w_dout !== 12'h3A5) begin errs++; $display("FAIL b2b_dout1: got %h want 3a5", w_dout); end
        checks++; if (w_cs_done !== 1'b1) begin errs++; $display("FAIL b2b_cs_gap: got %b want 1", w_cs_done); end
        newd = 1'b1;
        din  = 12'h0F0;
        watch(300, 0, 12'h000);
        checks++; if (w_cs_k1 !== 1'b0) begin errs++; $display("FAIL b2b_cs_refall: got %b want 0", w_cs_k1); end
        checks++; if (w_done_k != 101) begin errs++; $display("FAIL b2b_done_k2: got %0d want 101", w_done_k); end
        checks++; if (w_dout !== 12'h0F0) begin errs++; $display("FAIL b2b_dout2: got %h want 0f0", w_dout); end
    endtask

    task automatic test_abort;
        int seen;
        launch(12'hFFF, 1'b0, 1'b0, 1'b0, 1'b1);
        watch(49, 0, 12'h000);
        rst_n = 1'b0;
        #1;
        checks++; if (cs !== 1'b1) begin errs++; $display("FAIL abort_cs: got %b want 1", cs); end
        checks++; if (sclk !== 1'b0) begin errs++; $display("FAIL abort_sclk: got %b want 0", sclk); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (i == 3) rst_n = 1'b1;
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errs++; $display("FAIL abort_no_done: got %0d pulses want 0", seen); end
        launch(12'h3C3, 1'b0, 1'b0, 1'b0, 1'b1);
        watch(300, 0, 12'h000);
        checks++; if (w_done_k != 101) begin errs++; $display("FAIL abort_done_k: got %0d want 101", w_done_k); end
        checks++; if (w_dout !== 12'h3C3) begin errs++; $display("FAIL abort_dout: got %h want 3c3", w_dout); end
    endtask

    task automatic test_div1_w8;
        int   done_k, ntog, first_tog, last_tog;
        logic prev;
        logic [7:0] got;
        cpol8 = 1'b1; cpha8 = 1'b0; lsb8 = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (sclk8 !== 1'b1) begin errs++; $display("FAIL w8_idle_sclk: got %b want 1", sclk8); end
        newd8 = 1'b1;
        din8  = 8'hA5;
        done_k = 0; ntog = 0; first_tog = 0; last_tog = 0; got = '0;
        prev = sclk8;
        for (int k = 1; k <= 100 && done_k == 0; k++) begin
            @(posedge clk); #1;
            if (k == 1) newd8 = 1'b0;
            if (sclk8 !== prev) begin
                ntog++;
                if (first_tog == 0) first_tog = k;
                last_tog = k;
                prev = sclk8;
            end
            if (done8 === 1'b1) begin
                done_k = k;
                got    = dout8;
            end
        end
        checks++; if (first_tog != 2) begin errs++; $display("FAIL w8_first_edge: got %0d want 2", first_tog); end
        checks++; if (ntog != 16 || last_tog != 17) begin
            errs++; $display("FAIL w8_edges: got %0d edges ending %0d want 16 ending 17", ntog, last_tog);
        end
        checks++; if (done_k != 18) begin errs++; $display("FAIL w8_done_k: got %0d want 18", done_k); end
        checks++; if (got !== 8'hA5) begin errs++; $display("FAIL w8_dout: got %h want a5", got); end
    endtask

    initial begin
        test_reset();
        test_mode0_msb();
        test_mode3_slave();
        test_mode1_lsb();
        test_back_to_back();
        test_abort();
        test_div1_w8();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
